// File: rtl/ex_md_stage.sv
// ex_md_stage: execute stage with single-cycle ALU/compare ops and an
// iterative one-bit-per-cycle MUL/DIVU/REMU unit that stalls the pipeline.
`default_nettype none

module ex_md_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            t_in,
   input  logic [1:0]      t_op,
   input  logic            invert_t,
   input  logic            flush,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            t_out,
   output logic            stall
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] C_OP_MUL  = 4'd8;
   localparam logic [3:0] C_OP_DIVU = 4'd9;
   localparam logic [3:0] C_OP_REMU = 4'd10;
   localparam logic [1:0] C_K_MUL   = 2'd0;
   localparam logic [1:0] C_K_DIVU  = 2'd1;
   localparam logic [1:0] C_K_REMU  = 2'd2;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_kind;
   logic [XLEN-1:0]   r_a;     // multiplicand (MUL) or divisor (DIV)
   logic [XLEN-1:0]   r_b;     // multiplier (MUL) or dividend/quotient (DIV)
   logic [XLEN-1:0]   r_acc;   // product (MUL) or partial remainder (DIV)
   logic [XLEN-1:0]   r_res;

   logic              w_is_md;
   logic              w_issue;
   logic              w_last;
   logic [XLEN-1:0]   w_mul_acc;
   logic [XLEN:0]     w_rem_sh;
   logic              w_fit;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_alu_res;
   logic              w_cmp;
   logic              w_alu_t;

   assign w_is_md = (alu_op == C_OP_MUL) || (alu_op == C_OP_DIVU) || (alu_op == C_OP_REMU);
   assign w_issue = in_valid && w_is_md && !flush;
   assign w_last  = (r_cnt == CNT_W'(XLEN - 1));

   assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

   // Remainder stays below 2^XLEN, so the XLEN-bit subtraction is exact when it fits.
   assign w_rem_sh = {r_acc, r_b[XLEN-1]};
   assign w_fit    = (w_rem_sh >= {1'b0, r_a});
   assign w_rem    = w_fit ? (w_rem_sh[XLEN-1:0] - r_a) : w_rem_sh[XLEN-1:0];
   assign w_quo    = {r_b[XLEN-2:0], w_fit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_kind  <= C_K_MUL;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_res   <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_state <= S_RUN;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  if (alu_op == C_OP_MUL) begin
                     r_kind <= C_K_MUL;
                     r_a    <= op_a;
                     r_b    <= op_b;
                  end else begin
                     r_kind <= (alu_op == C_OP_DIVU) ? C_K_DIVU : C_K_REMU;
                     r_a    <= op_b;
                     r_b    <= op_a;
                  end
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_kind == C_K_MUL) begin
                  r_acc <= w_mul_acc;
                  r_a   <= r_a << 1;
                  r_b   <= r_b >> 1;
               end else begin
                  r_acc <= w_rem;
                  r_b   <= w_quo;
               end
               if (w_last) begin
                  r_state <= S_DONE;
                  case (r_kind)
                     C_K_MUL:  r_res <= w_mul_acc;
                     C_K_DIVU: r_res <= w_quo;
                     default:  r_res <= w_rem;
                  endcase
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_alu_res = '0;
      w_cmp     = 1'b0;
      case (alu_op)
         4'd0: w_alu_res = op_a + op_b;
         4'd1: w_alu_res = op_a - op_b;
         4'd2: w_alu_res = op_a & op_b;
         4'd3: w_alu_res = op_a | op_b;
         4'd4: w_alu_res = op_a ^ op_b;
         4'd5: w_cmp = (op_a == op_b);
         4'd6: w_cmp = (op_a >= op_b);
         4'd7: w_cmp = ($signed(op_a) >= $signed(op_b));
         default: w_alu_res = '0;
      endcase
      w_cmp = w_cmp ^ invert_t;
      case (t_op)
         2'd0:    w_alu_t = t_in & w_cmp;
         2'd1:    w_alu_t = t_in | w_cmp;
         2'd2:    w_alu_t = t_in ^ w_cmp;
         default: w_alu_t = w_cmp;
      endcase
      if (alu_op < 4'd5 || alu_op > 4'd7) begin
         w_alu_t = t_in;
      end
   end

   // Reset and flush both silence the stage combinationally.
   always_comb begin
      out_valid = 1'b0;
      result    = '0;
      t_out     = t_in;
      stall     = 1'b0;
      if (rst_n && !flush) begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && w_is_md) begin
                  stall = 1'b1;
               end else if (in_valid) begin
                  out_valid = 1'b1;
                  result    = w_alu_res;
                  t_out     = w_alu_t;
               end
            end
            S_RUN: stall = 1'b1;
            S_DONE: begin
               out_valid = 1'b1;
               result    = r_res;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
